// File: rtl/fetch_instr_queue.sv
// fetch_instr_queue: instruction FIFO between fetch and decode.
//   Buffers {instr, pc} pairs from fetch and hands them to decode in order
//   under a valid/ready handshake. Back-pressures fetch with stall_o when full;
//   flush_i discards every queued entry and the one presented in that cycle.
//
// Ports:
//   clk_i, rstn_i          clock, synchronous active-low reset
//   valid_i/instr_i/pc_i   fetch side: instruction presented this cycle
//   stall_o                queue full; derived from registered state only
//   flush_i                drop all queued and incoming instructions
//   valid_o/instr_o/pc_o   decode side: head entry (data zero when empty)
//   ready_i                decode accepts the head this cycle
//   level_o                occupancy, 0..DEPTH
//
// Parameter DEPTH must be a power of two and >= 2 (pointers wrap naturally).
//
// Optional feature macro: YARC_IQ_BYPASS_EN
//   When defined, an instruction arriving at an empty queue is shown on the
//   decode outputs in the same cycle; if decode accepts it, it is never written.
//   When undefined, there is no combinational path from fetch to decode.

module fetch_instr_queue #(
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk_i,
   input  logic                     rstn_i,
   input  logic                     valid_i,
   input  logic [31:0]              instr_i,
   input  logic [31:0]              pc_i,
   output logic                     stall_o,
   input  logic                     flush_i,
   output logic                     valid_o,
   output logic [31:0]              instr_o,
   output logic [31:0]              pc_o,
   input  logic                     ready_i,
   output logic [$clog2(DEPTH):0]   level_o
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [31:0]      instr_mem_q [DEPTH];
   logic [31:0]      pc_mem_q    [DEPTH];

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q,  count_d;

   logic             empty_c;
   logic             bypass_c;
   logic             push_c;
   logic             pop_c;

   // Handshake decode, output mux and next-state computation
   always_comb begin
      stall_o  = (count_q == CNT_W'(DEPTH));
      empty_c  = (count_q == '0);
      bypass_c = 1'b0;
`ifdef YARC_IQ_BYPASS_EN
      bypass_c = empty_c && valid_i && !flush_i;
`endif

      valid_o = !empty_c || bypass_c;
      instr_o = '0;
      pc_o    = '0;
      if (!empty_c) begin
         instr_o = instr_mem_q[rd_ptr_q];
         pc_o    = pc_mem_q[rd_ptr_q];
      end else if (bypass_c) begin
         instr_o = instr_i;
         pc_o    = pc_i;
      end

      // A bypassed entry accepted by decode skips storage entirely
      push_c = valid_i && !stall_o && !flush_i && !(bypass_c && ready_i);
      pop_c  = !empty_c && ready_i && !flush_i;

      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;

      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (pop_c)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
         case ({push_c, pop_c})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   assign level_o = count_q;

   // Control state; reset takes priority over flush and push/pop
   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Entry storage, intentionally not reset
   always_ff @(posedge clk_i) begin
      if (rstn_i && push_c) begin
         instr_mem_q[wr_ptr_q] <= instr_i;
         pc_mem_q[wr_ptr_q]    <= pc_i;
      end
   end

   // Fetch must not present an instruction while stalled; such an entry is lost
   always_ff @(posedge clk_i) begin
      if (rstn_i) begin
         assert (!(valid_i && stall_o))
            else $warning("fetch_instr_queue: valid_i asserted while stall_o high, entry dropped");
      end
   end

endmodule

// File: tb/tb_fetch_instr_queue.sv
module tb_fetch_instr_queue;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned LVL_W = $clog2(DEPTH) + 1;
   localparam int unsigned OBS_W = 2 + LVL_W + 64;

   logic              clk;
   logic              rstn_i;
   logic              valid_i;
   logic [31:0]       instr_i;
   logic [31:0]       pc_i;
   logic              stall_o;
   logic              flush_i;
   logic              valid_o;
   logic [31:0]       instr_o;
   logic [31:0]       pc_o;
   logic              ready_i;
   logic [LVL_W-1:0]  level_o;

   logic [OBS_W-1:0]  obs;
   logic [OBS_W-1:0]  exp_v;
   logic [31:0]       pc;

   int tests_run    = 0;
   int tests_failed = 0;

   fetch_instr_queue #(.DEPTH(DEPTH)) dut (
      .clk_i   (clk),
      .rstn_i  (rstn_i),
      .valid_i (valid_i),
      .instr_i (instr_i),
      .pc_i    (pc_i),
      .stall_o (stall_o),
      .flush_i (flush_i),
      .valid_o (valid_o),
      .instr_o (instr_o),
      .pc_o    (pc_o),
      .ready_i (ready_i),
      .level_o (level_o)
   );

   // Observation vector: {valid, stall, level, pc, instr}
   assign obs = {valid_o, stall_o, level_o, pc_o, instr_o};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] p);
      valid_i = v;
      pc_i    = p;
      instr_i = ~p;
   endtask

   task automatic test_reset();
      rstn_i = 1'b0;
      drive(1'b0, 32'h0);
      flush_i = 1'b0;
      ready_i = 1'b0;
      tick();
      tick();
      rstn_i = 1'b1;
      exp_v = '0;
      tests_run++;
      if (obs !== exp_v) begin
         tests_failed++;
         $display("FAIL reset_state got=%h exp=%h", obs, exp_v);
      end
   endtask

   task automatic test_latency();
      ready_i = 1'b1;
      valid_i = 1'b1;
      pc_i    = 32'h8000_0000;
      instr_i = 32'h0000_0013;
      #1;
`ifdef YARC_IQ_BYPASS_EN
      exp_v = {1'b1, 1'b0, 3'd0, 32'h8000_0000, 32'h0000_0013};
`else
      exp_v = '0;
`endif
      tests_run++;
      if (obs !== exp_v) begin
         tests_failed++;
         $display("FAIL latency_same_cycle got=%h exp=%h", obs, exp_v);
      end
      tick();
      drive(1'b0, 32'h0);
      #1;
`ifdef YARC_IQ_BYPASS_EN
      exp_v = '0;
`else
      exp_v = {1'b1, 1'b0, 3'd1, 32'h8000_0000, 32'h0000_0013};
`endif
      tests_run++;
      if (obs !== exp_v) begin
         tests_failed++;
         $display("FAIL latency_next_cycle got=%h exp=%h", obs, exp_v);
      end
      tick();
      exp_v = '0;
      tests_run++;
      if (obs !== exp_v) begin
         tests_failed++;
         $display("FAIL latency_drained got=%h exp=%h", obs, exp_v);
      end
   endtask

   task automatic test_fill_drain();
      ready_i = 1'b0;
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 32'h8000_0000 + 32'(4 * i));
         tick();
      end
      drive(1'b0, 32'h0);
      #1;
      pc = 32'h8000_0000;
      exp_v = {1'b1, 1'b1, 3'd4, pc, ~pc};
      tests_run++;
      if (obs !== exp_v) begin
         tests_failed++;
         $display("FAIL fill_full got=%h exp=%h", obs, exp_v);
      end
      // Protocol violation: entry presented while stalled must be dropped
      drive(1'b1, 32'hDEAD_BEE0);
      tick();
      drive(1'b0, 32'h0);
      #1;
      tests_run++;
      if (obs !== exp_v) begin
         tests_failed++;
         $display("FAIL drop_while_stalled got=%h exp=%h", obs, exp_v);
      end
      // Pop while full: stall stays high this cycle, then drops
      ready_i = 1'b1;
      #1;
      tests_run++;
      if (stall_o !== 1'b1) begin
         tests_failed++;
         $display("FAIL stall_in_pop_cycle got=%b exp=1", stall_o);
      end
      for (int i = 1; i < 4; i++) begin
         tick();
         pc = 32'h8000_0000 + 32'(4 * i);
         exp_v = {1'b1, 1'b0, 3'(4 - i), pc, ~pc};
         tests_run++;
         if (obs !== exp_v) begin
            tests_failed++;
            $display("FAIL drain_order_%0d got=%h exp=%h", i, obs, exp_v);
         end
      end
      tick();
      exp_v = '0;
      tests_run++;
      if (obs !== exp_v) begin
         tests_failed++;
         $display("FAIL drain_empty got=%h exp=%h", obs, exp_v);
      end
      // Empty with ready high: no underflow
      tick();
      tests_run++;
      if (obs !== exp_v) begin
         tests_failed++;
         $display("FAIL empty_ready_no_pop got=%h exp=%h", obs, exp_v);
      end
   endtask

   task automatic test_back_to_back();
      ready_i = 1'b0;
      for (int k = 0; k < 2; k++) begin
         drive(1'b1, 32'h8000_0200 + 32'(4 * k));
         tick();
      end
      ready_i = 1'b1;
      for (int i = 0; i < 10; i++) begin
         drive(1'b1, 32'h8000_0200 + 32'(4 * (i + 2)));
         tick();
         pc = 32'h8000_0200 + 32'(4 * (i + 1));
         exp_v = {1'b1, 1'b0, 3'd2, pc, ~pc};
         tests_run++;
         if (obs !== exp_v) begin
            tests_failed++;
            $display("FAIL steady_%0d got=%h exp=%h", i, obs, exp_v);
         end
      end
      drive(1'b0, 32'h0);
      tick();
      tick();
      exp_v = '0;
      tests_run++;
      if (obs !== exp_v) begin
         tests_failed++;
         $display("FAIL steady_drained got=%h exp=%h", obs, exp_v);
      end
   endtask

   task automatic test_flush();
      ready_i = 1'b0;
      for (int k = 0; k < 3; k++) begin
         drive(1'b1, 32'h8000_0300 + 32'(4 * k));
         tick();
      end
      drive(1'b1, 32'h8000_0050);
      ready_i = 1'b1;
      flush_i = 1'b1;
      tick();
      flush_i = 1'b0;
      drive(1'b0, 32'h0);
      #1;
      exp_v = '0;
      tests_run++;
      if (obs !== exp_v) begin
         tests_failed++;
         $display("FAIL flush_clears got=%h exp=%h", obs, exp_v);
      end
      ready_i = 1'b0;
      drive(1'b1, 32'h8000_0100);
      tick();
      drive(1'b0, 32'h0);
      #1;
      pc = 32'h8000_0100;
      exp_v = {1'b1, 1'b0, 3'd1, pc, ~pc};
      tests_run++;
      if (obs !== exp_v) begin
         tests_failed++;
         $display("FAIL flush_next_entry got=%h exp=%h", obs, exp_v);
      end
      ready_i = 1'b1;
      tick();
      exp_v = '0;
      tests_run++;
      if (obs !== exp_v) begin
         tests_failed++;
         $display("FAIL flush_drained got=%h exp=%h", obs, exp_v);
      end
   endtask

   task automatic test_reset_mid();
      ready_i = 1'b0;
      for (int k = 0; k < 2; k++) begin
         drive(1'b1, 32'h8000_0400 + 32'(4 * k));
         tick();
      end
      drive(1'b0, 32'h0);
      rstn_i = 1'b0;
      tick();
      rstn_i = 1'b1;
      exp_v = '0;
      tests_run++;
      if (obs !== exp_v) begin
         tests_failed++;
         $display("FAIL reset_mid got=%h exp=%h", obs, exp_v);
      end
      ready_i = 1'b1;
      tick();
      tick();
      tests_run++;
      if (obs !== exp_v) begin
         tests_failed++;
         $display("FAIL reset_no_replay got=%h exp=%h", obs, exp_v);
      end
   endtask

   initial begin
      test_reset();
      test_latency();
      test_fill_drain();
      test_back_to_back();
      test_flush();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
